// File: rtl/dec_to_bcd_pkg.sv
// Shared constants and types for the 4-bit binary-to-BCD digit converter.
// Widths, the single-digit limit and the tens offset live here so core and top agree.
// Optional tens support is selected by the DEC_TO_BCD_TENS_EN macro.
package dec_to_bcd_pkg;

  localparam int BIN_W = 4;
  localparam int BCD_W = 4;

  localparam logic [BIN_W-1:0] BCD_MAX     = 4'd9;
  localparam logic [BIN_W-1:0] TENS_OFFSET = 4'd10;

  // Digit code driven for out-of-range inputs when tens support is compiled out.
  localparam logic [BCD_W-1:0] ERR_CODE = 4'b1111;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/dec_to_bcd_core.sv
// Combinational binary-to-BCD digit split for values 0..15.
// Latency: zero, purely combinational.
// Backpressure: none; output follows dec_in continuously. Tens output exists only with DEC_TO_BCD_TENS_EN.
module dec_to_bcd_core
  import dec_to_bcd_pkg::*;
(
  input  logic [BIN_W-1:0] dec_in,
  output logic [BCD_W-1:0] digit,
`ifdef DEC_TO_BCD_TENS_EN
  output logic             tens,
`endif
  output logic             err
);

  logic in_rng;

  assign in_rng = (dec_in <= BCD_MAX);

`ifdef DEC_TO_BCD_TENS_EN
  // Values 10..15 fold into tens=1 plus a ones digit of 0..5; nothing is out of range.
  always_comb begin
    digit = dec_in;
    tens  = 1'b0;
    err   = 1'b0;
    if (!in_rng) begin
      // Only 10..15 reach here, so the 4-bit subtraction never wraps.
      digit = dec_in - TENS_OFFSET;
      tens  = 1'b1;
    end
  end
`else
  // Without a tens digit, values above 9 cannot be represented and are flagged.
  always_comb begin
    digit = dec_in;
    err   = 1'b0;
    if (!in_rng) begin
      digit = ERR_CODE;
      err   = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/dec_to_bcd.sv
// Registered 4-bit binary-to-BCD digit converter with out-of-range flag (tens digit with DEC_TO_BCD_TENS_EN).
// Latency: 1 cycle, one conversion per cycle; all outputs come straight from flops.
// Backpressure: none; every valid input yields exactly one out_valid pulse, results hold while idle.
module dec_to_bcd
  import dec_to_bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] dec_in,
  input  logic             in_valid,
  output logic [BCD_W-1:0] bcd_out,
`ifdef DEC_TO_BCD_TENS_EN
  output logic             bcd_tens,
`endif
  output logic             out_valid,
  output logic             err
);

  bcd_digit_t digit;
  logic       digit_err;
`ifdef DEC_TO_BCD_TENS_EN
  logic       digit_tens;
`endif

  dec_to_bcd_core u_core (
    .dec_in (dec_in),
    .digit  (digit),
`ifdef DEC_TO_BCD_TENS_EN
    .tens   (digit_tens),
`endif
    .err    (digit_err)
  );

  // Valid pipeline: one out_valid pulse per accepted sample; reset wins over in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
    end
  end

  // Result registers capture only on valid samples and otherwise hold the last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_out <= '0;
      err     <= 1'b0;
    end else if (in_valid) begin
      bcd_out <= digit;
      err     <= digit_err;
    end
  end

`ifdef DEC_TO_BCD_TENS_EN
  // Tens register follows the same capture/hold rule as the ones digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_tens <= 1'b0;
    end else if (in_valid) begin
      bcd_tens <= digit_tens;
    end
  end
`endif

endmodule

// File: tb/tb_dec_to_bcd.sv
// Scoreboard bench for dec_to_bcd: driver pushes hand-computed expectations, monitor pops on out_valid.
// Between results the monitor checks that outputs hold, or read zero after a reset edge.
// Works with and without DEC_TO_BCD_TENS_EN.
module tb_dec_to_bcd;

  typedef struct {
    logic [3:0] d;
    logic       t;
    logic       e;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] dec_in;
  logic       in_valid;
  logic [3:0] bcd_out;
  logic       out_valid;
  logic       err;
`ifdef DEC_TO_BCD_TENS_EN
  logic       bcd_tens;
`endif

  exp_t q[$];
  exp_t held;
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  logic samp_vld = 1'b0;
  logic samp_rst = 1'b0;
  logic mon_en   = 1'b0;

  dec_to_bcd dut (
    .clk       (clk),
    .rst       (rst),
    .dec_in    (dec_in),
    .in_valid  (in_valid),
    .bcd_out   (bcd_out),
`ifdef DEC_TO_BCD_TENS_EN
    .bcd_tens  (bcd_tens),
`endif
    .out_valid (out_valid),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b, want %b", name, $time, act, exp);
    end
  endtask

  // What the DUT should have seen on each edge.
  always @(posedge clk) begin
    samp_vld <= in_valid & ~rst;
    samp_rst <= rst;
  end

  // Monitor: compare outputs mid-cycle against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", {3'b0, out_valid}, {3'b0, samp_vld});
      if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result at %0t: got bcd_out=%b, want no result", $time, bcd_out);
        end else begin
          cur  = q.pop_front();
          held = cur;
        end
      end else if (samp_rst) begin
        held = '{d: 4'd0, t: 1'b0, e: 1'b0};
      end
      chk("bcd_out", bcd_out, held.d);
      chk("err", {3'b0, err}, {3'b0, held.e});
`ifdef DEC_TO_BCD_TENS_EN
      chk("bcd_tens", {3'b0, bcd_tens}, {3'b0, held.t});
`endif
    end
  end

  // Drive one valid sample; the expectation is queued unless this edge is a reset edge.
  task automatic send(input logic [3:0] v, input logic [3:0] d, input logic t, input logic e);
    dec_in   = v;
    in_valid = 1'b1;
    if (!rst) q.push_back('{d: d, t: t, e: e});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [3:0] v, input int n);
    dec_in   = v;
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    held     = '{d: 4'd0, t: 1'b0, e: 1'b0};
    rst      = 1'b1;
    in_valid = 1'b1;
    dec_in   = 4'd7;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    // Reset held with valid input present: inputs discarded.
    send(4'd7, 4'd0, 1'b0, 1'b0);
    send(4'd7, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // In-range sweep, back to back.
    send(4'd0, 4'b0000, 1'b0, 1'b0);
    send(4'd1, 4'b0001, 1'b0, 1'b0);
    send(4'd2, 4'b0010, 1'b0, 1'b0);
    send(4'd4, 4'b0100, 1'b0, 1'b0);
    send(4'd9, 4'b1001, 1'b0, 1'b0);

    // Boundary around 9/10 and the top code.
    send(4'd9, 4'b1001, 1'b0, 1'b0);
`ifdef DEC_TO_BCD_TENS_EN
    send(4'd10, 4'b0000, 1'b1, 1'b0);
    send(4'd15, 4'b0101, 1'b1, 1'b0);
    send(4'd12, 4'b0010, 1'b1, 1'b0);
`else
    send(4'd10, 4'b1111, 1'b0, 1'b1);
    send(4'd15, 4'b1111, 1'b0, 1'b1);
    send(4'd12, 4'b1111, 1'b0, 1'b1);
`endif
    send(4'd8, 4'b1000, 1'b0, 1'b0);

    // Hold: one result, then idle with a changing input.
    send(4'd4, 4'b0100, 1'b0, 1'b0);
    idle(4'd9, 3);

    // Out-of-range then idle, so the held flag is exercised too.
`ifdef DEC_TO_BCD_TENS_EN
    send(4'd13, 4'b0011, 1'b1, 1'b0);
`else
    send(4'd13, 4'b1111, 1'b0, 1'b1);
`endif
    idle(4'd2, 2);

    // Reset mid-stream.
    send(4'd3, 4'b0011, 1'b0, 1'b0);
    rst = 1'b1;
    send(4'd5, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    idle(4'd5, 1);
    send(4'd6, 4'b0110, 1'b0, 1'b0);
`ifdef DEC_TO_BCD_TENS_EN
    send(4'd11, 4'b0001, 1'b1, 1'b0);
`else
    send(4'd11, 4'b1111, 1'b0, 1'b1);
`endif
    send(4'd7, 4'b0111, 1'b0, 1'b0);
    idle(4'd0, 3);

    // Every queued expectation must have been matched by a result.
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding, want 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dec_to_bcd.md
# dec_to_bcd

Registered 4-bit binary-to-BCD digit converter. Accepts a binary value 0..15 with a valid strobe and produces the BCD digit one clock later, flagging codes outside the single-digit range 0..9. It sits on a sampled numeric input path, feeding BCD-consuming logic such as display drivers or decimal formatters.

## Interface
- ERR_CODE, 4'b1111, digit value driven on bcd_out when the input is out of range and tens support is compiled out.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous and active-high.
- dec_in  input  4  binary value to convert, 0..15.
- in_valid  input  1  dec_in is sampled on a rising clk edge where in_valid=1.
- bcd_out  output  4  registered BCD ones digit.
- bcd_tens  output  1  registered tens digit, 0 or 1. Present only with DEC_TO_BCD_TENS_EN.
- out_valid  output  1  bcd_out, err and bcd_tens hold a new result this cycle.
- err  output  1  registered out-of-range flag.
- The block has one clock. Reset is synchronous and active-high.

## Operation
- Combinational core: in_rng = (dec_in <= 9).
- If in_rng: digit = dec_in, tens = 0, err = 0.
- If not in_rng, the result depends on the tens configuration:
  - With tens support: digit = dec_in − 10 (4-bit, range 0..5), tens = 1, err = 0.
  - Without tens support: digit = ERR_CODE, err = 1.
- On each clk edge with in_valid=1:
  - Register digit into bcd_out, tens into bcd_tens and err into err.
  - Set out_valid=1.
- On each clk edge with in_valid=0:
  - out_valid goes to 0.
  - bcd_out, bcd_tens and err hold their last values.
- Arithmetic is unsigned 4-bit. No wrap-around is possible, because only 10..15 are subtracted.
- There is no backpressure. Every valid input yields exactly one out_valid pulse.

## Timing
- Latency: 1 cycle. Input sampled at edge N; result visible after edge N, valid during cycle N+1.
- Throughput: one conversion per cycle. Back-to-back in_valid produces back-to-back out_valid.
- Reset values, applied at any edge with rst=1: bcd_out=0, bcd_tens=0, err=0, out_valid=0.
- rst has priority over in_valid. A valid input on a reset edge is discarded.
- Reset mid-stream: the first out_valid after reset comes one cycle after the first valid sample taken with rst=0.
- No combinational path from inputs to outputs.

## Configuration
- Macro: DEC_TO_BCD_TENS_EN.
- Defined:
  - bcd_tens port exists.
  - Inputs 10..15 convert to tens=1 with ones 0..5.
  - err is tied to 0.
  - ERR_CODE is unused.
- Undefined:
  - No bcd_tens port.
  - Inputs 10..15 give bcd_out=ERR_CODE and err=1.

## Structure
- Package dec_to_bcd_pkg holds:
  - BIN_W=4 and BCD_W=4.
  - BCD_MAX=4'd9 and TENS_OFFSET=4'd10.
  - Typedef bcd_digit_t (logic [3:0]).
- Sub-module dec_to_bcd_core: purely combinational, dec_in → {digit, tens, err}.
- Top level dec_to_bcd: input/output registers, valid pipeline and reset.

## Test plan
- Reset: hold rst=1 for 2 cycles with in_valid=1, dec_in=7 → bcd_out=0, err=0, out_valid=0 throughout.
- In-range sweep: dec_in 0,1,2,4,9 on consecutive cycles with in_valid=1 → bcd_out 0000,0001,0010,0100,1001 one cycle later each, err=0, out_valid continuously 1.
- Boundary without macro: dec_in=9 then 10 → bcd_out 1001/err=0, then 1111/err=1. dec_in=15 → 1111/err=1.
- Boundary with DEC_TO_BCD_TENS_EN: dec_in=10 → tens=1, bcd_out=0000. dec_in=15 → tens=1, bcd_out=0101. err=0 in both cases.
- Hold: send dec_in=4 valid, then change dec_in to 9 with in_valid=0 for 3 cycles → bcd_out stays 0100, out_valid=0 after the first result cycle.
- Reset mid-stream: assert rst for one edge during a valid stream → outputs clear to 0 the next cycle. Conversions resume with 1-cycle latency after release.
